// File: rtl/iscas_stim_misr.sv
// BIST wrapper for an ISCAS sequential circuit: LFSR stimulus, flush phase, MISR response compaction.
// Defining ISCAS_SIG_COMPARE_EN compiles in a registered golden-signature compare on pass.
module iscas_stim_misr #(
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter int unsigned NUM_VECTORS  = 1024,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [2:0]  stim,
   input  logic [5:0]  resp,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic        pass
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FlushW-1:0] FlushLast =
      FlushW'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);
   localparam logic [15:0] VecLast = 16'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [15:0]       misr_q, misr_d;
   logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]       vec_cnt_q, vec_cnt_d;
   logic [15:0]       lfsr_next, misr_next;

   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign misr_next = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
                      ^ {10'b0, resp};

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      misr_d      = misr_q;
      flush_cnt_d = flush_cnt_q;
      vec_cnt_d   = vec_cnt_q;
      stim        = 3'b000;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = (FLUSH_CYCLES == 0) ? StRun : StFlush;
               lfsr_d      = LfsrInit;
               misr_d      = 16'h0000;
               flush_cnt_d = '0;
               vec_cnt_d   = 16'h0000;
            end
         end
         StFlush: begin
            // G0 held high clears the circuit's state flops.
            stim = 3'b001;
            busy = 1'b1;
            if (flush_cnt_q == FlushLast) begin
               state_d = StRun;
            end else begin
               flush_cnt_d = flush_cnt_q + FlushW'(1);
            end
         end
         StRun: begin
            stim   = lfsr_q[2:0];
            busy   = 1'b1;
            lfsr_d = lfsr_next;
            misr_d = misr_next;
            if (vec_cnt_q == VecLast) begin
               state_d = StDone;
            end else begin
               vec_cnt_d = vec_cnt_q + 16'h0001;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         lfsr_q      <= LfsrInit;
         misr_q      <= 16'h0000;
         flush_cnt_q <= '0;
         vec_cnt_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         misr_q      <= misr_d;
         flush_cnt_q <= flush_cnt_d;
         vec_cnt_q   <= vec_cnt_d;
      end
   end

   assign signature = misr_q;

`ifdef ISCAS_SIG_COMPARE_EN
   logic pass_q, pass_d;

   always_comb begin
      pass_d = pass_q;
      if (state_q == StIdle && start) begin
         pass_d = 1'b0;
      end else if (state_q == StDone) begin
         pass_d = (misr_q == GOLDEN_SIG);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_q <= 1'b0;
      end else begin
         pass_q <= pass_d;
      end
   end

   assign pass = pass_q;
`else
   assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_iscas_stim_misr.sv
// Bench for iscas_stim_misr: timeline model of the main instance checked every cycle, plus
// directed literal checks on small-parameter instances.
module tb_iscas_stim_misr;

   localparam int          F        = 2;
   localparam int          N        = 100;
   localparam logic [15:0] SeedMain = 16'hACE1;
   localparam logic [15:0] GoldMain = 16'h0000;
`ifdef ISCAS_SIG_COMPARE_EN
   localparam bit CompareEn = 1'b1;
`else
   localparam bit CompareEn = 1'b0;
`endif

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic start     = 1'b0;
   logic start_aux = 1'b0;
   logic use_toy   = 1'b0;

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0]  stim;
   logic [5:0]  resp;
   logic        busy, done, pass;
   logic [15:0] signature;

   // Small sequential stand-in for the circuit under test; two cycles of G0=1 clear it.
   logic [2:0] toy_q;
   always @(posedge clk or posedge rst) begin
      if (rst) toy_q <= 3'b101;
      else     toy_q <= {toy_q[1] ^ stim[2], toy_q[0] & stim[1], ~stim[0] & (toy_q[2] | stim[1])};
   end
   assign resp = use_toy ? {toy_q, toy_q ^ stim} : 6'h00;

   iscas_stim_misr #(
      .FLUSH_CYCLES(F),
      .NUM_VECTORS (N),
      .SEED        (SeedMain),
      .GOLDEN_SIG  (GoldMain)
   ) u_main (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stim     (stim),
      .resp     (resp),
      .busy     (busy),
      .done     (done),
      .signature(signature),
      .pass     (pass)
   );

   logic [2:0]  stim_n1, stim_n2, stim_n2b, stim_s0;
   logic        busy_n1, busy_n2, busy_n2b, busy_s0;
   logic        done_n1, done_n2, done_n2b, done_s0;
   logic        pass_n1, pass_n2, pass_n2b, pass_s0;
   logic [15:0] sig_n1, sig_n2, sig_n2b, sig_s0;
   logic [5:0]  resp_s0;
   assign resp_s0 = {3'b000, stim_s0};

   iscas_stim_misr #(.NUM_VECTORS(1)) u_n1 (
      .clk(clk), .rst(rst), .start(start_aux), .stim(stim_n1), .resp(6'h01),
      .busy(busy_n1), .done(done_n1), .signature(sig_n1), .pass(pass_n1)
   );
   iscas_stim_misr #(.NUM_VECTORS(2), .GOLDEN_SIG(16'h0003)) u_n2 (
      .clk(clk), .rst(rst), .start(start_aux), .stim(stim_n2), .resp(6'h01),
      .busy(busy_n2), .done(done_n2), .signature(sig_n2), .pass(pass_n2)
   );
   iscas_stim_misr #(.NUM_VECTORS(2), .GOLDEN_SIG(16'h0002)) u_n2b (
      .clk(clk), .rst(rst), .start(start_aux), .stim(stim_n2b), .resp(6'h01),
      .busy(busy_n2b), .done(done_n2b), .signature(sig_n2b), .pass(pass_n2b)
   );
   iscas_stim_misr #(.FLUSH_CYCLES(0), .NUM_VECTORS(3), .SEED(16'h0000)) u_s0 (
      .clk(clk), .rst(rst), .start(start_aux), .stim(stim_s0), .resp(resp_s0),
      .busy(busy_s0), .done(done_s0), .signature(sig_s0), .pass(pass_s0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] step16(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Model: m_t is the position within a run (1..F flush, F+1..F+N vectors, F+N+1 done).
   int          m_t    = -1;
   logic [15:0] m_lfsr = SeedMain;
   logic [15:0] m_sig  = 16'h0000;
   logic        m_pass = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t    <= -1;
         m_sig  <= 16'h0000;
         m_pass <= 1'b0;
      end else if (m_t < 0) begin
         if (start) begin
            m_t    <= 1;
            m_sig  <= 16'h0000;
            m_lfsr <= SeedMain;
            m_pass <= 1'b0;
         end
      end else if (m_t <= F) begin
         m_t <= m_t + 1;
      end else if (m_t <= F + N) begin
         m_sig  <= step16(m_sig) ^ {10'b0, resp};
         m_lfsr <= step16(m_lfsr);
         m_t    <= m_t + 1;
      end else begin
         m_pass <= (m_sig == GoldMain);
         m_t    <= -1;
      end
   end

   always @(negedge clk) begin : cmp
      logic       in_flush, in_run, in_done;
      logic [2:0] e_stim;
      in_flush = (m_t >= 1) && (m_t <= F);
      in_run   = (m_t > F) && (m_t <= F + N);
      in_done  = (m_t == F + N + 1);
      e_stim   = in_flush ? 3'b001 : (in_run ? m_lfsr[2:0] : 3'b000);
      chk("model stim", 32'(stim), 32'(e_stim));
      chk("model busy", 32'(busy), 32'(in_flush || in_run));
      chk("model done", 32'(done), 32'(in_done));
      chk("model signature", 32'(signature), 32'(m_sig));
      chk("model pass", 32'(pass), 32'(CompareEn & m_pass));
   end

   task automatic pulse_and_wait(input int limit, output int cycles);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (!done && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      chk("done within budget", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          k;
      int          nd;
      int          cyc;
      int          d_cyc[3];
      logic [15:0] d_sig[3];
      logic [15:0] sig_ref;

      repeat (3) @(negedge clk);
      chk("reset stim", 32'(stim), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset signature", 32'(signature), 32'd0);
      chk("reset pass", 32'(pass), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Run A: resp tied low, flush/first-vector stimulus and done latency
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("flush1 stim", 32'(stim), 32'h1);
      @(negedge clk);
      chk("flush2 stim", 32'(stim), 32'h1);
      @(negedge clk);
      chk("run1 stim", 32'(stim), 32'h1);
      @(negedge clk);
      chk("run2 stim", 32'(stim), 32'h3);
      k = 4;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
         start = (k == 10);
      end
      chk("runA done latency", 32'(k), 32'd103);
      chk("runA signature", 32'(signature), 32'h0000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start in DONE ignored", 32'(busy), 32'd0);
      chk("runA pass", 32'(pass), 32'(CompareEn));
      @(negedge clk);
      chk("stays idle", 32'(busy), 32'd0);
      chk("runA signature held", 32'(signature), 32'h0000);

      // Run B: uninterrupted run with the stand-in circuit attached
      use_toy = 1'b1;
      pulse_and_wait(300, k);
      chk("runB done latency", 32'(k), 32'd103);
      sig_ref = signature;
      repeat (2) @(negedge clk);

      // Run C: reset at vector 50, then a fresh run
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (k < F + 50) begin
         @(negedge clk);
         k++;
      end
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst signature", 32'(signature), 32'd0);
      chk("async rst stim", 32'(stim), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no run without start", 32'(busy), 32'd0);
      pulse_and_wait(300, k);
      chk("runC done latency", 32'(k), 32'd103);
      chk("runC signature after abort", 32'(signature), 32'(sig_ref));
      repeat (2) @(negedge clk);

      // Run D: start held high, three back-to-back runs
      start = 1'b1;
      nd    = 0;
      cyc   = 0;
      for (int i = 0; i < 3; i++) begin
         d_cyc[i] = 0;
         d_sig[i] = 16'h0000;
      end
      while (nd < 3 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            d_cyc[nd] = cyc;
            d_sig[nd] = signature;
            nd++;
         end
      end
      start = 1'b0;
      chk("b2b done count", 32'(nd), 32'd3);
      chk("b2b spacing 1", 32'(d_cyc[1] - d_cyc[0]), 32'(N + F + 2));
      chk("b2b spacing 2", 32'(d_cyc[2] - d_cyc[1]), 32'(N + F + 2));
      for (int i = 0; i < 3; i++) begin
         chk("b2b signature", 32'(d_sig[i]), 32'(sig_ref));
      end
      repeat (3) @(negedge clk);

      // Small-parameter instances
      start_aux = 1'b1;
      @(negedge clk);
      start_aux = 1'b0;
      chk("seed0 run1 stim", 32'(stim_s0), 32'h1);
      @(negedge clk);
      chk("seed0 run2 stim", 32'(stim_s0), 32'h2);
      @(negedge clk);
      chk("seed0 run3 stim", 32'(stim_s0), 32'h4);
      @(negedge clk);
      chk("seed0 done", 32'(done_s0), 32'd1);
      chk("seed0 done stim", 32'(stim_s0), 32'h0);
      repeat (10) @(negedge clk);
      chk("seed0 signature", 32'(sig_s0), 32'h0004);
      chk("n1 signature", 32'(sig_n1), 32'h0001);
      chk("n2 signature", 32'(sig_n2), 32'h0003);
      chk("n2b signature", 32'(sig_n2b), 32'h0003);
      chk("n2 pass golden match", 32'(pass_n2), 32'(CompareEn));
      chk("n2b pass golden flipped", 32'(pass_n2b), 32'd0);
      chk("aux idle", 32'({busy_n1, busy_n2, busy_n2b, busy_s0}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
